// File: rtl/adder_issue_pkg.sv
// Shared types and default sizing for the adder issue controller.
package adder_issue_pkg;

  localparam int unsigned DefWidth     = 16;
  localparam int unsigned DefLatency   = 2;
  localparam int unsigned DefFifoDepth = 4;

  typedef enum logic [1:0] {
    StWarmup,
    StRun,
    StFault
  } state_e;

  typedef struct packed {
    logic                carry;
    logic [DefWidth-1:0] sum;
  } result_t;

endpackage

// File: rtl/adder_issue_ctrl_if.sv
// Upstream operand, downstream result and adder-facing signals of the issue controller.
interface adder_issue_ctrl_if #(
  parameter int unsigned WIDTH = adder_issue_pkg::DefWidth
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             adder_ce;
  logic [WIDTH-1:0] adder_a;
  logic [WIDTH-1:0] adder_b;
  logic             adder_valid;
  logic [WIDTH-1:0] adder_s;
  logic             fault;

  // Controller side.
  modport slave (
    input  in_valid, in_a, in_b, out_ready, adder_valid, adder_s,
    output in_ready, out_valid, out_sum, out_carry, adder_ce, adder_a, adder_b, fault
  );

  // Environment side: upstream producer, downstream consumer and the adder itself.
  modport master (
    output in_valid, in_a, in_b, out_ready, adder_valid, adder_s,
    input  in_ready, out_valid, out_sum, out_carry, adder_ce, adder_a, adder_b, fault
  );
endinterface

// File: rtl/adder_result_fifo.sv
// Synchronous result FIFO; pointers wrap modulo Depth, count has one extra bit for "full".
module adder_result_fifo #(
  parameter int unsigned Width = 17,
  parameter int unsigned Depth = 4,
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [CntW-1:0]  count_o,
  output logic [Width-1:0] head_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0]  count_q, count_d;

  function automatic logic [PtrW-1:0] wrap_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_comb begin
    wr_d    = push_i ? wrap_inc(wr_q) : wr_q;
    rd_d    = pop_i ? wrap_inc(rd_q) : rd_q;
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the head is only consumed while count is non-zero.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/adder_issue_ctrl.sv
// Issue controller for the pipelined adder: keeps CE high, tracks in-flight ops against the
// adder latency and returns {carry, sum} through a credit-protected result FIFO.
module adder_issue_ctrl
  import adder_issue_pkg::*;
#(
  parameter int unsigned WIDTH      = DefWidth,
  parameter int unsigned LATENCY    = DefLatency,
  parameter int unsigned FIFO_DEPTH = DefFifoDepth
) (
  input logic               clk,
  input logic               rst_n,
  adder_issue_ctrl_if.slave bus
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned InfW = $clog2(LATENCY + 1);

  state_e                          state_q, state_d;
  logic                            ce_q;
  logic [LATENCY-1:0]              flag_q, flag_d;
  logic [LATENCY-1:0][WIDTH-1:0]   a_q, a_d;
  logic [InfW-1:0]                 inflight_q, inflight_d;
  logic [CntW-1:0]                 fifo_count;
  logic [WIDTH:0]                  fifo_head;
  logic [31:0]                     credit;
  logic                            running, issue, capture, pop, out_valid, carry;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StWarmup: if (bus.adder_valid) state_d = StRun;
      StRun:    if (!bus.adder_valid) state_d = StFault;
      StFault:  state_d = StFault;
      default:  state_d = StWarmup;
    endcase
  end

  // A same-cycle pop frees its credit immediately; push only moves an op from in-flight to FIFO.
  always_comb begin
    running   = (state_q == StRun);
    out_valid = (fifo_count != '0);
    pop       = out_valid && bus.out_ready;
    credit    = 32'(fifo_count) + 32'(inflight_q) - 32'(pop);
    issue     = running && bus.in_valid && (credit < FIFO_DEPTH);
    capture   = flag_q[LATENCY-1] && running && bus.adder_valid;
    carry     = (bus.adder_s < a_q[LATENCY-1]);
  end

  always_comb begin
    flag_d[0] = issue;
    a_d[0]    = bus.in_a;
    for (int i = 1; i < LATENCY; i++) begin
      flag_d[i] = flag_q[i-1];
      a_d[i]    = a_q[i-1];
    end
    case ({issue, flag_q[LATENCY-1]})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StWarmup;
      ce_q       <= 1'b0;
      flag_q     <= '0;
      a_q        <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      ce_q       <= 1'b1;
      flag_q     <= flag_d;
      a_q        <= a_d;
      inflight_q <= inflight_d;
    end
  end

  adder_result_fifo #(
    .Width (WIDTH + 1),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (capture),
    .data_i  ({carry, bus.adder_s}),
    .pop_i   (pop),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

  assign bus.in_ready  = running && (credit < FIFO_DEPTH);
  assign bus.adder_ce  = ce_q;
  assign bus.adder_a   = issue ? bus.in_a : '0;
  assign bus.adder_b   = issue ? bus.in_b : '0;
  assign bus.out_valid = out_valid;
  assign bus.out_sum   = out_valid ? fifo_head[WIDTH-1:0] : '0;
  assign bus.out_carry = out_valid && fifo_head[WIDTH];
  assign bus.fault     = (state_q == StFault);

endmodule

// File: tb/tb_adder_issue_ctrl.sv
// Scoreboard bench for adder_issue_ctrl with a behavioural 2-stage adder model.
module tb_adder_issue_ctrl;
  import adder_issue_pkg::*;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] s;
    logic        c;
  } vec_t;

  logic clk, rst_n, force_invalid;
  int   total, bad;
  int   ov_cycles, cur_run, max_run;
  result_t exp_q [$];
  vec_t    tbl   [0:20];

  adder_issue_ctrl_if #(.WIDTH(16)) bus ();

  adder_issue_ctrl #(
    .WIDTH      (16),
    .LATENCY    (2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Adder model: CE low clears the valid pipeline; result appears 2 cycles after sampling.
  logic [1:0][15:0] s_pipe;
  logic [1:0]       v_pipe;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_pipe <= '0;
      v_pipe <= '0;
    end else if (!bus.adder_ce) begin
      v_pipe <= '0;
    end else begin
      s_pipe <= {s_pipe[0], bus.adder_a + bus.adder_b};
      v_pipe <= {v_pipe[0], 1'b1};
    end
  end
  assign bus.adder_valid = v_pipe[1] & ~force_invalid;
  assign bus.adder_s     = s_pipe[1];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid) begin
        ov_cycles++;
        cur_run++;
        if (cur_run > max_run) max_run = cur_run;
      end else begin
        cur_run = 0;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got sum %h carry %b expected none", bus.out_sum,
                   bus.out_carry);
        end else begin
          result_t r;
          r = exp_q.pop_front();
          chk("result_sum", 32'(bus.out_sum), 32'(r.sum));
          chk("result_carry", 32'(bus.out_carry), 32'(r.carry));
        end
      end
    end
  end

  // Offer tbl[idx] until accepted; expectation is queued only for kept ops.
  task automatic send(input int idx, input bit keep, output int waits);
    bit done;
    done  = 1'b0;
    waits = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = tbl[idx].a;
    bus.in_b     = tbl[idx].b;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        if (keep) exp_q.push_back('{carry: tbl[idx].c, sum: tbl[idx].s});
        done = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready 0 for 100 cycles expected 1 (vector %0d)", idx);
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.out_valid) ok = 1'b1;
    end
    chk("drain_complete", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx, w, wsum;
    total = 0; bad = 0; ov_cycles = 0; cur_run = 0; max_run = 0;
    tbl[0]  = '{16'h1234, 16'h0001, 16'h1235, 1'b0};
    tbl[1]  = '{16'hFFFF, 16'h0002, 16'h0001, 1'b1};
    tbl[2]  = '{16'h8000, 16'h8000, 16'h0000, 1'b1};
    tbl[3]  = '{16'h0001, 16'h0001, 16'h0002, 1'b0};
    tbl[4]  = '{16'h0010, 16'h0020, 16'h0030, 1'b0};
    tbl[5]  = '{16'h0100, 16'h0200, 16'h0300, 1'b0};
    tbl[6]  = '{16'h1000, 16'h2000, 16'h3000, 1'b0};
    tbl[7]  = '{16'h7FFF, 16'h0001, 16'h8000, 1'b0};
    tbl[8]  = '{16'hFFFE, 16'h0003, 16'h0001, 1'b1};
    tbl[9]  = '{16'h0000, 16'h0000, 16'h0000, 1'b0};
    tbl[10] = '{16'h0001, 16'hFFFF, 16'h0000, 1'b1};
    tbl[11] = '{16'h1111, 16'h2222, 16'h3333, 1'b0};
    tbl[12] = '{16'hABCD, 16'h1234, 16'hBE01, 1'b0};
    tbl[13] = '{16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1};
    tbl[14] = '{16'h5555, 16'hAAAA, 16'hFFFF, 1'b0};
    tbl[15] = '{16'h8001, 16'h7FFF, 16'h0000, 1'b1};
    tbl[16] = '{16'h0F0F, 16'hF0F1, 16'h0000, 1'b1};
    tbl[17] = '{16'h0042, 16'h0001, 16'h0043, 1'b0};
    tbl[18] = '{16'hF000, 16'h1000, 16'h0000, 1'b1};
    tbl[19] = '{16'h0003, 16'h0004, 16'h0007, 1'b0};
    tbl[20] = '{16'h0005, 16'h0006, 16'h000B, 1'b0};

    rst_n = 1'b0; force_invalid = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b1;
    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_sum", 32'(bus.out_sum), 0);
    chk("rst_out_carry", 32'(bus.out_carry), 0);
    chk("rst_adder_ce", 32'(bus.adder_ce), 0);
    chk("rst_adder_a", 32'(bus.adder_a), 0);
    chk("rst_adder_b", 32'(bus.adder_b), 0);
    chk("rst_fault", 32'(bus.fault), 0);

    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ce_first_edge", 32'(bus.adder_ce), 1);
    @(negedge clk);
    chk("warm_adder_valid_low", 32'(bus.adder_valid), 0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("warm_adder_valid_high", 32'(bus.adder_valid), 1);
    chk("warm_in_ready_low", 32'(bus.in_ready), 0);
    @(negedge clk);
    chk("run_in_ready", 32'(bus.in_ready), 1);
    chk("run_fault", 32'(bus.fault), 0);

    // Single op with latency probe.
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_a = tbl[0].a; bus.in_b = tbl[0].b;
    @(negedge clk);
    chk("single_in_ready", 32'(bus.in_ready), 1);
    chk("single_adder_a", 32'(bus.adder_a), 32'h1234);
    chk("single_adder_b", 32'(bus.adder_b), 32'h0001);
    exp_q.push_back('{carry: tbl[0].c, sum: tbl[0].s});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("lat_t1_out_valid", 32'(bus.out_valid), 0);
    chk("idle_adder_a", 32'(bus.adder_a), 0);
    @(negedge clk);
    chk("lat_t2_out_valid", 32'(bus.out_valid), 0);
    @(negedge clk);
    chk("lat_t3_out_valid", 32'(bus.out_valid), 1);
    drain();

    // Carry-out cases.
    send(1, 1'b1, w);
    send(2, 1'b1, w);
    bus.in_valid = 1'b0;
    drain();

    // Backpressure: six offered, four accepted while out_ready is low.
    bus.out_ready = 1'b0;
    idx = 3;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (idx < 9) begin
        bus.in_valid = 1'b1; bus.in_a = tbl[idx].a; bus.in_b = tbl[idx].b;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back('{carry: tbl[idx].c, sum: tbl[idx].s});
        idx++;
      end
      @(posedge clk); #1;
    end
    chk("bp_accepted", 32'(idx - 3), 32'd4);
    @(negedge clk);
    chk("bp_in_ready_low", 32'(bus.in_ready), 0);
    chk("bp_out_valid", 32'(bus.out_valid), 1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    while (idx < 9) begin
      send(idx, 1'b1, w);
      idx++;
    end
    bus.in_valid = 1'b0;
    drain();

    // Sustained throughput.
    ov_cycles = 0; cur_run = 0; max_run = 0; wsum = 0;
    for (int i = 9; i < 17; i++) begin
      send(i, 1'b1, w);
      wsum += w;
    end
    bus.in_valid = 1'b0;
    drain();
    chk("tput_ready_stalls", 32'(wsum), 0);
    chk("tput_out_cycles", 32'(ov_cycles), 32'd8);
    chk("tput_max_run", 32'(max_run), 32'd8);

    // Fault: two buffered results survive, two in-flight ops are dropped.
    bus.out_ready = 1'b0;
    send(17, 1'b1, w);
    send(18, 1'b1, w);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send(19, 1'b0, w);
    send(20, 1'b0, w);
    force_invalid = 1'b1;
    @(negedge clk);
    chk("fault_not_yet", 32'(bus.fault), 0);
    @(posedge clk); #1;
    chk("fault_set", 32'(bus.fault), 1);
    chk("fault_in_ready", 32'(bus.in_ready), 0);
    chk("fault_adder_ce", 32'(bus.adder_ce), 1);
    force_invalid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("fault_sticky", 32'(bus.fault), 1);
    chk("fault_no_ready", 32'(bus.in_ready), 0);
    chk("fault_buffered", 32'(bus.out_valid), 1);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    chk("fault_after_drain", 32'(bus.fault), 1);

    // Asynchronous reset mid-cycle.
    bus.in_valid = 1'b1; bus.in_a = tbl[0].a; bus.in_b = tbl[0].b;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_fault", 32'(bus.fault), 0);
    chk("arst_adder_ce", 32'(bus.adder_ce), 0);
    chk("arst_in_ready", 32'(bus.in_ready), 0);
    chk("arst_out_valid", 32'(bus.out_valid), 0);
    chk("arst_out_sum", 32'(bus.out_sum), 0);
    chk("arst_adder_a", 32'(bus.adder_a), 0);
    exp_q.delete();
    bus.in_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("rewarm_in_ready", 32'(bus.in_ready), 0);
    chk("rewarm_adder_ce", 32'(bus.adder_ce), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
